aes_io_sequencer: RTL

Sequencer that sits between the host word interface and the AES-128 datapath. It feeds four 32-bit input words into `ShiftRegister32to128` and pulses the AES core's start once the 128-bit block is assembled. It then waits for the core to finish and returns the 128-bit result to the host as four 32-bit words over a valid/ready handshake.

---
 rtl/aes_io_pkg.sv | 24 ++
 rtl/aes_io_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/aes_io_pkg.sv
// Shared widths, state encoding and word-select helper for the AES host I/O sequencer.
package aes_io_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned NUM_WORDS  = 4;
  localparam int unsigned WORD_IDX_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } seq_state_t;

  // Word 0 is the most significant word of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0]    blk,
                                                   input logic [WORD_IDX_W-1:0] idx);
    logic [BLOCK_W-1:0] shifted;
    shifted = blk << (32'(idx) * WORD_W);
    return shifted[BLOCK_W-1 -: WORD_W];
  endfunction

endpackage

// File: rtl/aes_io_sequencer.sv
// Loads four host words into the external 32->128 shift register, starts the AES core,
// waits (bounded) for its result and streams the 128-bit result back MSB word first.
module aes_io_sequencer
  import aes_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic [WORD_W-1:0]  sr_data,
  output logic               sr_shift,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0]     TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS - 1);

  seq_state_t              state, state_d;
  logic [WORD_IDX_W-1:0]   word_cnt, word_cnt_d;
  logic [TCNT_W-1:0]       tcnt, tcnt_d;
  logic [BLOCK_W-1:0]      res_q, res_d;
  logic                    err_d;

  // Host-facing strobes are pure state decodes so they never depend on valid/ready.
  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == UNLOAD);
  assign core_start = (state == START);
  assign busy       = (state != LOAD);
  assign sr_data    = in_data;
  assign sr_shift   = in_valid & in_ready;
  assign out_data   = out_valid ? block_word(res_q, word_cnt) : '0;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      word_cnt    <= '0;
      tcnt        <= '0;
      res_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      word_cnt    <= word_cnt_d;
      tcnt        <= tcnt_d;
      res_q       <= res_d;
      timeout_err <= err_d;
    end
  end

  // Next-state logic; word_cnt is shared by the load and unload phases.
  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    tcnt_d     = tcnt;
    res_d      = res_q;
    err_d      = timeout_err;
    case (state)
      LOAD: begin
        if (sr_shift) begin
          word_cnt_d = word_cnt + WORD_IDX_W'(1);
          if (word_cnt == LAST_WORD) state_d = START;
        end
      end
      START: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d = tcnt + TCNT_W'(1);
        // A done on the terminal cycle still counts as a success.
        if (core_done) begin
          res_d      = core_result;
          word_cnt_d = '0;
          state_d    = UNLOAD;
        end else if (tcnt == TCNT_LAST) begin
          err_d   = 1'b1;
          state_d = LOAD;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          word_cnt_d = word_cnt + WORD_IDX_W'(1);
          if (word_cnt == LAST_WORD) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule
